// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: opcode encodings, FSM
// state encoding and the default legal-opcode mask.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_SRA = 4'd2;
    localparam logic [3:0] OP_ROL = 4'd3;
    localparam logic [3:0] OP_AND = 4'd8;
    localparam logic [3:0] OP_OR  = 4'd9;
    localparam logic [3:0] OP_XOR = 4'd10;
    localparam logic [3:0] OP_NOT = 4'd11;
    localparam logic [3:0] OP_SLL = 4'd12;
    localparam logic [3:0] OP_SRL = 4'd13;

    // One bit per opcode, 1 = legal.
    localparam logic [15:0] OP_VALID_DEFAULT = 16'h3F0F;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } state_e;

endpackage

// File: rtl/alu_issue_ctrl.sv
// Operand/command master for the 16-bit ALU core. Takes one request from
// decode, drives the ALU from registers, waits out the ALU latency, captures
// the result and hands it to writeback.
// Optional feature: define ALU_ISSUE_FLAGS_EN to register {N,Z} flags;
// otherwise rsp_flags is tied to zero.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned ALU_LATENCY = 1,
    parameter logic [15:0] OP_VALID    = OP_VALID_DEFAULT,
    parameter int unsigned TAG_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [15:0]      req_a,
    input  logic [15:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic [3:0]       alu_op,
    output logic [15:0]      alu_a,
    output logic [15:0]      alu_b,
    input  logic [15:0]      alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [15:0]      rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err,
    output logic [1:0]       rsp_flags
);

    localparam int unsigned CNT_W = ($clog2(ALU_LATENCY + 1) < 1) ? 1 : $clog2(ALU_LATENCY + 1);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [3:0]         alu_op_q;
    logic [15:0]        alu_a_q;
    logic [15:0]        alu_b_q;
    logic [15:0]        data_q;
    logic [TAG_W-1:0]   tag_q;
    logic               err_q;
    logic               accept;

    // Ready only when no response is pending, or the pending one leaves this edge.
    assign req_ready = (state_q == StIdle) | ((state_q == StResp) & rsp_ready);
    assign accept    = req_valid & req_ready;

    assign alu_op    = alu_op_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign rsp_valid = (state_q == StResp);
    assign rsp_data  = data_q;
    assign rsp_tag   = tag_q;
    assign rsp_err   = err_q;

`ifdef ALU_ISSUE_FLAGS_EN
    logic [1:0] flags_q;
    assign rsp_flags = flags_q;
`else
    assign rsp_flags = 2'b00;
`endif

    // Issue FSM: accept, wait for the ALU result, hold the response.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            alu_op_q <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            data_q   <= '0;
            tag_q    <= '0;
            err_q    <= 1'b0;
`ifdef ALU_ISSUE_FLAGS_EN
            flags_q  <= 2'b00;
`endif
        end else begin
            unique case (state_q)
                StIdle, StResp: begin
                    if (accept) begin
                        tag_q <= req_tag;
                        if (OP_VALID[req_op]) begin
                            alu_op_q <= req_op;
                            alu_a_q  <= req_a;
                            alu_b_q  <= req_b;
                            cnt_q    <= CNT_W'(ALU_LATENCY);
                            state_q  <= StWait;
                        end else begin
                            // Illegal op never reaches the ALU; respond immediately.
                            data_q  <= '0;
                            err_q   <= 1'b1;
`ifdef ALU_ISSUE_FLAGS_EN
                            flags_q <= 2'b01;
`endif
                            state_q <= StResp;
                        end
                    end else if (state_q == StResp && rsp_ready) begin
                        state_q <= StIdle;
                    end
                end
                StWait: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        data_q  <= alu_result;
                        err_q   <= 1'b0;
`ifdef ALU_ISSUE_FLAGS_EN
                        flags_q <= {alu_result[15], alu_result == 16'h0000};
`endif
                        state_q <= StResp;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl paired with a one-stage behavioural ALU core.
// Expected responses are queued at request time and checked on rsp_valid.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    localparam int unsigned TAG_W  = 4;
    localparam int unsigned LAT    = 1;
    localparam logic [15:0] LEGAL  = 16'h3F0F;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [3:0]       req_op = '0;
    logic [15:0]      req_a = '0;
    logic [15:0]      req_b = '0;
    logic [TAG_W-1:0] req_tag = '0;
    logic [3:0]       alu_op;
    logic [15:0]      alu_a;
    logic [15:0]      alu_b;
    logic [15:0]      alu_result = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [15:0]      rsp_data;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err;
    logic [1:0]       rsp_flags;

    typedef struct packed {
        logic [15:0]      data;
        logic [TAG_W-1:0] tag;
        logic             err;
        logic [1:0]       flags;
    } rsp_t;

    rsp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [3:0]  last_op = '0;
    logic [15:0] last_a = '0;
    logic [15:0] last_b = '0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(
        .ALU_LATENCY (LAT),
        .OP_VALID    (LEGAL),
        .TAG_W       (TAG_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_tag    (req_tag),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_tag    (rsp_tag),
        .rsp_err    (rsp_err),
        .rsp_flags  (rsp_flags)
    );

    function automatic logic [15:0] alu_fn(input logic [3:0] op, input logic [15:0] a,
                                           input logic [15:0] b);
        logic [15:0] r;
        logic [3:0]  s;
        s = b[3:0];
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_SRA:  r = $signed(a) >>> s;
            OP_ROL:  r = (a << s) | (a >> (5'd16 - {1'b0, s}));
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NOT:  r = ~a;
            OP_SLL:  r = a << s;
            OP_SRL:  r = a >> s;
            default: r = 16'h0000;
        endcase
        return r;
    endfunction

    // Behavioural ALU core with one register stage.
    always_ff @(posedge clk) alu_result <= alu_fn(alu_op, alu_a, alu_b);

    function automatic rsp_t model(input logic [3:0] op, input logic [15:0] a,
                                   input logic [15:0] b, input logic [TAG_W-1:0] tag);
        rsp_t        e;
        logic [15:0] legal;
        legal = LEGAL;
        e.tag = tag;
        if (legal[op]) begin
            e.data  = alu_fn(op, a, b);
            e.err   = 1'b0;
`ifdef ALU_ISSUE_FLAGS_EN
            e.flags = {e.data[15], e.data == 16'h0000};
`else
            e.flags = 2'b00;
`endif
        end else begin
            e.data  = 16'h0000;
            e.err   = 1'b1;
`ifdef ALU_ISSUE_FLAGS_EN
            e.flags = 2'b01;
`else
            e.flags = 2'b00;
`endif
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a request, wait for the handshake edge, return #1 after it.
    task automatic do_req(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [TAG_W-1:0] tag, input bit push);
        logic [15:0] legal;
        legal     = LEGAL;
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (push) sb.push_back(model(op, a, b, tag));
        if (legal[op]) begin
            last_op = op;
            last_a  = a;
            last_b  = b;
        end
    endtask

    // Count edges from the accept edge to rsp_valid, then check the response.
    task automatic expect_rsp(input int lat_exp);
        int   k;
        rsp_t e;
        k = 0;
        while (!rsp_valid && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("rsp_latency", k, lat_exp);
        chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("rsp_data", {16'd0, rsp_data}, {16'd0, e.data});
            chk("rsp_tag", {28'd0, rsp_tag}, {28'd0, e.tag});
            chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
            chk("rsp_flags", {30'd0, rsp_flags}, {30'd0, e.flags});
        end else begin
            chk("scoreboard_nonempty", {31'd0, rsp_valid}, 32'd0);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, "_rsp_data"}, {16'd0, rsp_data}, 32'd0);
        chk({tag, "_rsp_tag"}, {28'd0, rsp_tag}, 32'd0);
        chk({tag, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
        chk({tag, "_rsp_flags"}, {30'd0, rsp_flags}, 32'd0);
        chk({tag, "_alu_op"}, {28'd0, alu_op}, 32'd0);
        chk({tag, "_alu_a"}, {16'd0, alu_a}, 32'd0);
        chk({tag, "_alu_b"}, {16'd0, alu_b}, 32'd0);
        chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    endtask

    logic [3:0]  tbl_op[10] = '{OP_XOR, OP_ROL, OP_SRA, OP_NOT, 4'hF, OP_AND, OP_OR, OP_SRL,
                                4'h4, OP_ROL};
    logic [15:0] tbl_a[10]  = '{16'hA5A5, 16'h8001, 16'h8000, 16'h00FF, 16'h1111, 16'hF0F0,
                                16'h0F00, 16'h8000, 16'h2222, 16'h1234};
    logic [15:0] tbl_b[10]  = '{16'h5A5A, 16'h0004, 16'h0003, 16'h0000, 16'h2222, 16'h3C3C,
                                16'h00F0, 16'h000F, 16'h3333, 16'h0000};

    initial begin
        logic [15:0] legal;
        legal = LEGAL;

        // Reset state
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("reset");
        rst = 1'b1;
        @(posedge clk);
        #1;

        // ADD 3+4, then drain to idle
        do_req(OP_ADD, 16'h0003, 16'h0004, 4'd5, 1'b1);
        expect_rsp(LAT + 1);
        @(posedge clk);
        #1;
        chk("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("idle_req_ready", {31'd0, req_ready}, 32'd1);

        // Negative and zero results, issued back-to-back
        do_req(OP_SUB, 16'h0001, 16'h0002, 4'd1, 1'b1);
        expect_rsp(LAT + 1);
        do_req(OP_SUB, 16'h1234, 16'h1234, 4'd3, 1'b1);
        expect_rsp(LAT + 1);

        // Illegal opcode: immediate error response, ALU inputs untouched
        do_req(4'h5, 16'hDEAD, 16'hBEEF, 4'd2, 1'b1);
        expect_rsp(0);
        chk("illegal_alu_op_held", {28'd0, alu_op}, {28'd0, last_op});
        chk("illegal_alu_a_held", {16'd0, alu_a}, {16'd0, last_a});
        chk("illegal_alu_b_held", {16'd0, alu_b}, {16'd0, last_b});

        // Mixed opcodes including more illegal ones
        for (int i = 0; i < 10; i++) begin
            do_req(tbl_op[i], tbl_a[i], tbl_b[i], 4'(i + 6), 1'b1);
            expect_rsp(legal[tbl_op[i]] ? LAT + 1 : 0);
        end

        // Writeback stall with a queued request, then same-edge accept
        @(posedge clk);
        #1;
        do_req(OP_ADD, 16'h0001, 16'h0001, 4'd7, 1'b1);
        rsp_ready = 1'b0;
        expect_rsp(LAT + 1);
        req_valid = 1'b1;
        req_op    = OP_SLL;
        req_a     = 16'h0001;
        req_b     = 16'h0004;
        req_tag   = 4'd9;
        sb.push_back(model(OP_SLL, 16'h0001, 16'h0004, 4'd9));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("stall_rsp_data", {16'd0, rsp_data}, 32'h0002);
            chk("stall_rsp_tag", {28'd0, rsp_tag}, 32'd7);
            chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("unstall_req_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        last_op = OP_SLL;
        last_a  = 16'h0001;
        last_b  = 16'h0004;
        expect_rsp(LAT + 1);
        @(posedge clk);
        #1;

        // Reset while waiting on the ALU drops the request
        do_req(OP_ADD, 16'h0005, 16'h0006, 4'd4, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        chk_reset_state("midreset");
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("midreset_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end

        // Normal operation after reset
        do_req(OP_ADD, 16'h0003, 16'h0004, 4'd5, 1'b1);
        expect_rsp(LAT + 1);
        @(posedge clk);
        #1;
        chk("final_idle", {31'd0, rsp_valid}, 32'd0);
        chk("final_sb_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
